// File: rtl/pre_post_pkg.sv
// rtl/pre_post_pkg.sv - shared constants and types for the 36/24-bit pixel packers
package pre_post_pkg;

   localparam int CH_W   = 12;
   localparam int CH_HI  = 24;
   localparam int CH_MID = 12;
   localparam int CH_LO  = 0;

   localparam logic [12:0] ROUND_BIAS = 13'd8;
   localparam logic [11:0] SAT_LIMIT  = 12'd4088;

   typedef enum logic [1:0] {
      WAIT_VS = 2'd0,
      IN_VS   = 2'd1,
      LOCKED  = 2'd2
   } lock_state_t;

endpackage

// File: rtl/px_conv12to8.sv
// rtl/px_conv12to8.sv - one channel 12-bit to 8-bit, truncate or round-half-up with saturation
module px_conv12to8
   import pre_post_pkg::*;
(
   input  logic [CH_W-1:0] x,
   input  logic            round_en,
   output logic [7:0]      y
);

   logic [12:0] sum;
   logic        unused_sum_bits;

   assign sum             = {1'b0, x} + ROUND_BIAS;
   assign unused_sum_bits = ^{sum[12], sum[3:0]};

   // Codes at or above SAT_LIMIT would carry into bit 12; clamp instead of wrapping.
   always_comb begin
      if (!round_en)
         y = x[11:4];
      else if (x >= SAT_LIMIT)
         y = 8'hFF;
      else
         y = sum[11:4];
   end

endmodule

// File: rtl/preprocess_pipe.sv
// rtl/preprocess_pipe.sv - 36-bit 12bpc to 24-bit 8bpc pipeline with frame lock and geometry
module preprocess_pipe
   import pre_post_pkg::*;
#(
   parameter int CNT_W  = 12,
   parameter bit VS_POL = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             round_en,
   input  logic             de_in,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic [35:0]      video_in,
   output logic             de_out,
   output logic             hsync_out,
   output logic             vsync_out,
   output logic [23:0]      video_out,
   output logic             frame_locked,
   output logic [CNT_W-1:0] line_px,
   output logic [CNT_W-1:0] frame_lines
);

   logic [35:0]      video_s1;
   logic             de_s1, hs_s1, vs_s1, rnd_s1;
   logic             vs_q, de_q;
   logic             vs_rise, vs_fall, de_fall, locked;
   lock_state_t      state, state_next;
   logic [CNT_W-1:0] px_cnt, ln_cnt, ln_next;
   logic [7:0]       c_hi, c_mid, c_lo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         video_s1 <= '0;
         de_s1    <= 1'b0;
         hs_s1    <= 1'b0;
         vs_s1    <= 1'b0;
         rnd_s1   <= 1'b0;
         vs_q     <= 1'b0;
         de_q     <= 1'b0;
      end else begin
         video_s1 <= video_in;
         de_s1    <= de_in;
         hs_s1    <= hsync_in;
         vs_s1    <= (vsync_in == VS_POL);
         rnd_s1   <= round_en;
         vs_q     <= vs_s1;
         de_q     <= de_s1;
      end
   end

   assign vs_rise = vs_s1 & ~vs_q;
   assign vs_fall = ~vs_s1 & vs_q;
   assign de_fall = ~de_s1 & de_q;
   assign locked  = (state == LOCKED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= WAIT_VS;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         WAIT_VS: if (vs_rise) state_next = IN_VS;
         IN_VS:   if (vs_fall) state_next = LOCKED;
         LOCKED:  state_next = LOCKED;
         default: state_next = WAIT_VS;
      endcase
   end

   px_conv12to8 u_conv_hi  (.x(video_s1[CH_HI  +: CH_W]), .round_en(rnd_s1), .y(c_hi));
   px_conv12to8 u_conv_mid (.x(video_s1[CH_MID +: CH_W]), .round_en(rnd_s1), .y(c_mid));
   px_conv12to8 u_conv_lo  (.x(video_s1[CH_LO  +: CH_W]), .round_en(rnd_s1), .y(c_lo));

   // Gating uses the pre-update state so the pixel that carries the lock edge is still blanked.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_out       <= 1'b0;
         hsync_out    <= 1'b0;
         vsync_out    <= 1'b0;
         video_out    <= '0;
         frame_locked <= 1'b0;
      end else begin
         de_out       <= de_s1 & locked;
         hsync_out    <= hs_s1;
         vsync_out    <= vs_s1 ~^ VS_POL;
         video_out    <= locked ? {c_mid, c_lo, c_hi} : 24'h0;
         frame_locked <= (state_next == LOCKED);
      end
   end

   // A de fall on the vsync edge is counted into the frame it closes.
   assign ln_next = (de_fall && ln_cnt != '1) ? ln_cnt + CNT_W'(1) : ln_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px_cnt      <= '0;
         ln_cnt      <= '0;
         line_px     <= '0;
         frame_lines <= '0;
      end else begin
         if (de_fall) begin
            line_px <= px_cnt;
            px_cnt  <= '0;
         end else if (de_s1 && px_cnt != '1) begin
            px_cnt <= px_cnt + CNT_W'(1);
         end
         if (vs_rise) begin
            frame_lines <= ln_next;
            ln_cnt      <= '0;
         end else begin
            ln_cnt <= ln_next;
         end
      end
   end

endmodule

// File: tb/tb_preprocess_pipe.sv
// tb/tb_preprocess_pipe.sv - self-checking bench for preprocess_pipe
module tb_preprocess_pipe;

   logic        clk, rst_n, round_en, de_in, hsync_in, vsync_in;
   logic [35:0] video_in;
   logic        de_out, hsync_out, vsync_out, frame_locked;
   logic [23:0] video_out;
   logic [11:0] line_px, frame_lines;

   int n_checks = 0;
   int n_errors = 0;

   preprocess_pipe #(.CNT_W(12), .VS_POL(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .round_en(round_en), .de_in(de_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .video_in(video_in),
      .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
      .video_out(video_out), .frame_locked(frame_locked),
      .line_px(line_px), .frame_lines(frame_lines)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: previous input record plus frame-level bookkeeping
   bit          have_prev;
   logic        p_de, p_hs, p_vs, p_rnd, p_gate;
   logic [35:0] p_vid;
   logic        m_last_de, m_last_vs, m_seen_hi, m_locked;
   int          m_run, m_lines, m_lp, m_fl;
   logic        e_de, e_hs, e_vs, e_fl;
   logic [23:0] e_vid;
   int          e_lp, e_fln;

   function automatic logic [7:0] conv_ref(input logic [11:0] x, input logic r);
      int xi, v;
      xi = int'(x);
      v  = r ? (xi + 8) / 16 : xi / 16;
      if (v > 255) v = 255;
      return v[7:0];
   endfunction

   task automatic model_reset();
      have_prev = 0;
      m_last_de = 0; m_last_vs = 0; m_seen_hi = 0; m_locked = 0;
      m_run = 0; m_lines = 0; m_lp = 0; m_fl = 0;
      e_de = 0; e_hs = 0; e_vs = 0; e_fl = 0; e_vid = '0; e_lp = 0; e_fln = 0;
   endtask

   // Apply one input record, clock it in, and derive what the outputs must now show.
   task automatic drive(input logic de, input logic hs, input logic vs,
                        input logic [35:0] vid, input logic rnd);
      de_in = de; hsync_in = hs; vsync_in = vs; video_in = vid; round_en = rnd;
      @(posedge clk); #2;
      if (have_prev) begin
         e_de  = p_de & p_gate;
         e_hs  = p_hs;
         e_vs  = p_vs;
         e_vid = p_gate ? {conv_ref(p_vid[23:12], p_rnd), conv_ref(p_vid[11:0], p_rnd),
                           conv_ref(p_vid[35:24], p_rnd)} : 24'h0;
         if (p_de) begin
            m_run = (m_run < 4095) ? m_run + 1 : 4095;
         end else if (m_last_de) begin
            m_lp    = m_run;
            m_run   = 0;
            m_lines = (m_lines < 4095) ? m_lines + 1 : 4095;
         end
         if (p_vs && !m_last_vs) begin
            m_fl    = m_lines;
            m_lines = 0;
         end
         if (p_vs) m_seen_hi = 1;
         else if (m_seen_hi) m_locked = 1;
         m_last_de = p_de;
         m_last_vs = p_vs;
      end else begin
         e_de = 0; e_hs = 0; e_vs = 0; e_vid = '0;
      end
      e_fl = m_locked; e_lp = m_lp; e_fln = m_fl;
      p_de = de; p_hs = hs; p_vs = vs; p_vid = vid; p_rnd = rnd; p_gate = m_locked;
      have_prev = 1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; de_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; round_en = 1'b1;
      video_in = 36'hFFF_FFF_FFF;
      repeat (3) @(posedge clk);
      #2;
      n_checks++; if (de_out !== 1'b0) begin n_errors++; $display("FAIL reset_de got=%b exp=0", de_out); end
      n_checks++; if (hsync_out !== 1'b0) begin n_errors++; $display("FAIL reset_hs got=%b exp=0", hsync_out); end
      n_checks++; if (vsync_out !== 1'b0) begin n_errors++; $display("FAIL reset_vs got=%b exp=0", vsync_out); end
      n_checks++; if (video_out !== 24'h0) begin n_errors++; $display("FAIL reset_video got=%h exp=0", video_out); end
      n_checks++; if (frame_locked !== 1'b0) begin n_errors++; $display("FAIL reset_locked got=%b exp=0", frame_locked); end
      n_checks++; if (line_px !== 12'd0) begin n_errors++; $display("FAIL reset_line_px got=%0d exp=0", line_px); end
      n_checks++; if (frame_lines !== 12'd0) begin n_errors++; $display("FAIL reset_frame_lines got=%0d exp=0", frame_lines); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_unlocked();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, 1'b0, 36'hFF0_AB0_120, 1'b0);
         n_checks++; if (de_out !== 1'b0 || de_out !== e_de) begin n_errors++; $display("FAIL unlocked_de got=%b exp=0", de_out); end
         n_checks++; if (video_out !== 24'h0) begin n_errors++; $display("FAIL unlocked_video got=%h exp=0", video_out); end
         n_checks++; if (frame_locked !== 1'b0) begin n_errors++; $display("FAIL unlocked_locked got=%b exp=0", frame_locked); end
      end
   endtask

   task automatic test_lock_and_map();
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 36'h0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 36'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b0, 36'hFF0_AB0_120, 1'b0);
         n_checks++; if (de_out !== e_de) begin n_errors++; $display("FAIL lock_de got=%b exp=%b", de_out, e_de); end
         n_checks++; if (video_out !== e_vid) begin n_errors++; $display("FAIL lock_video got=%h exp=%h", video_out, e_vid); end
         n_checks++; if (frame_locked !== e_fl) begin n_errors++; $display("FAIL lock_flag got=%b exp=%b", frame_locked, e_fl); end
      end
      n_checks++; if (video_out !== 24'hAB12FF) begin n_errors++; $display("FAIL map_video got=%h exp=ab12ff", video_out); end
      n_checks++; if (de_out !== 1'b1) begin n_errors++; $display("FAIL map_de got=%b exp=1", de_out); end
      n_checks++; if (frame_locked !== 1'b1) begin n_errors++; $display("FAIL map_locked got=%b exp=1", frame_locked); end
   endtask

   task automatic test_rounding();
      logic [35:0] tbl [6];
      logic        rnd_tbl [6];
      tbl[0] = {12'h0F7, 12'h0F8, 12'hFFF}; rnd_tbl[0] = 1'b1;
      tbl[1] = {12'hFF7, 12'hFF8, 12'h008}; rnd_tbl[1] = 1'b1;
      tbl[2] = {12'h007, 12'h000, 12'hFF0}; rnd_tbl[2] = 1'b1;
      tbl[3] = {12'hFFF, 12'h0F8, 12'h7FF}; rnd_tbl[3] = 1'b0;
      tbl[4] = {12'hFEF, 12'hFF0, 12'h017}; rnd_tbl[4] = 1'b1;
      tbl[5] = 36'h0;                       rnd_tbl[5] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, 1'b0, tbl[i], rnd_tbl[i]);
         n_checks++; if (video_out !== e_vid) begin n_errors++; $display("FAIL round_video[%0d] got=%h exp=%h", i, video_out, e_vid); end
         if (i == 1) begin
            n_checks++; if (video_out !== 24'h10FF0F) begin n_errors++; $display("FAIL round_sat got=%h exp=10ff0f", video_out); end
         end
      end
   endtask

   task automatic test_geometry();
      // Open a fresh frame, then 479 one-pixel lines and a final 640-pixel line.
      for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b1, 36'h0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 36'h0, 1'b0);
      for (int l = 0; l < 479; l++) begin
         drive(1'b1, 1'b0, 1'b0, 36'($urandom), 1'b0);
         drive(1'b0, 1'b1, 1'b0, 36'h0, 1'b0);
         if (l % 97 == 5) begin
            n_checks++; if (line_px !== 12'(e_lp)) begin n_errors++; $display("FAIL geo_short_line got=%0d exp=%0d", line_px, e_lp); end
         end
      end
      for (int p = 0; p < 640; p++) drive(1'b1, 1'b0, 1'b0, 36'($urandom), 1'b0);
      drive(1'b0, 1'b1, 1'b0, 36'h0, 1'b0);
      n_checks++; if (line_px !== 12'd1) begin n_errors++; $display("FAIL geo_before_fall got=%0d exp=1", line_px); end
      drive(1'b0, 1'b0, 1'b0, 36'h0, 1'b0);
      n_checks++; if (line_px !== 12'd640) begin n_errors++; $display("FAIL geo_line_px got=%0d exp=640", line_px); end
      n_checks++; if (frame_lines !== 12'(e_fln)) begin n_errors++; $display("FAIL geo_pre_vs got=%0d exp=%0d", frame_lines, e_fln); end
      drive(1'b0, 1'b0, 1'b1, 36'h0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 36'h0, 1'b0);
      n_checks++; if (frame_lines !== 12'd480) begin n_errors++; $display("FAIL geo_frame_lines got=%0d exp=480", frame_lines); end
      drive(1'b0, 1'b0, 1'b0, 36'h0, 1'b0);
      // Three 4-pixel lines; the third de fall lands on the vsync rising edge.
      for (int l = 0; l < 3; l++) begin
         for (int p = 0; p < 4; p++) drive(1'b1, 1'b0, 1'b0, 36'h123_456_789, 1'b0);
         drive(1'b0, 1'b0, (l == 2) ? 1'b1 : 1'b0, 36'h0, 1'b0);
      end
      drive(1'b0, 1'b0, 1'b1, 36'h0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 36'h0, 1'b0);
      n_checks++; if (frame_lines !== 12'd3 || frame_lines !== 12'(e_fln)) begin n_errors++; $display("FAIL geo_coincident got=%0d exp=3", frame_lines); end
      n_checks++; if (line_px !== 12'd4) begin n_errors++; $display("FAIL geo_short_px got=%0d exp=4", line_px); end
   endtask

   task automatic test_random();
      logic vs;
      vs = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 15) == 0) vs = ~vs;
         drive(1'($urandom), 1'($urandom), vs, {$urandom, $urandom}, 1'($urandom));
         n_checks++; if (hsync_out !== e_hs) begin n_errors++; $display("FAIL rnd_hs[%0d] got=%b exp=%b", i, hsync_out, e_hs); end
         n_checks++; if (vsync_out !== e_vs) begin n_errors++; $display("FAIL rnd_vs[%0d] got=%b exp=%b", i, vsync_out, e_vs); end
         n_checks++; if (de_out !== e_de) begin n_errors++; $display("FAIL rnd_de[%0d] got=%b exp=%b", i, de_out, e_de); end
         n_checks++; if (video_out !== e_vid) begin n_errors++; $display("FAIL rnd_video[%0d] got=%h exp=%h", i, video_out, e_vid); end
         n_checks++; if (line_px !== 12'(e_lp)) begin n_errors++; $display("FAIL rnd_line_px[%0d] got=%0d exp=%0d", i, line_px, e_lp); end
         n_checks++; if (frame_lines !== 12'(e_fln)) begin n_errors++; $display("FAIL rnd_frame_lines[%0d] got=%0d exp=%0d", i, frame_lines, e_fln); end
      end
   endtask

   task automatic test_midline_reset();
      drive(1'b0, 1'b0, 1'b0, 36'h0, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 36'hABC_DEF_123, 1'b1);
      n_checks++; if (de_out !== 1'b1) begin n_errors++; $display("FAIL pre_reset_de got=%b exp=1", de_out); end
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (de_out !== 1'b0) begin n_errors++; $display("FAIL async_de got=%b exp=0", de_out); end
      n_checks++; if (hsync_out !== 1'b0) begin n_errors++; $display("FAIL async_hs got=%b exp=0", hsync_out); end
      n_checks++; if (video_out !== 24'h0) begin n_errors++; $display("FAIL async_video got=%h exp=0", video_out); end
      n_checks++; if (frame_locked !== 1'b0) begin n_errors++; $display("FAIL async_locked got=%b exp=0", frame_locked); end
      n_checks++; if (line_px !== 12'd0) begin n_errors++; $display("FAIL async_line_px got=%0d exp=0", line_px); end
      n_checks++; if (frame_lines !== 12'd0) begin n_errors++; $display("FAIL async_frame_lines got=%0d exp=0", frame_lines); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 1'b0, (i >= 4 && i < 6) ? 1'b1 : 1'b0, 36'hFF0_AB0_120, 1'b0);
         n_checks++; if (de_out !== e_de) begin n_errors++; $display("FAIL relock_de[%0d] got=%b exp=%b", i, de_out, e_de); end
         n_checks++; if (frame_locked !== e_fl) begin n_errors++; $display("FAIL relock_flag[%0d] got=%b exp=%b", i, frame_locked, e_fl); end
         n_checks++; if (video_out !== e_vid) begin n_errors++; $display("FAIL relock_video[%0d] got=%h exp=%h", i, video_out, e_vid); end
         if (i < 6) begin
            n_checks++; if (de_out !== 1'b0) begin n_errors++; $display("FAIL wait_vs_de[%0d] got=%b exp=0", i, de_out); end
         end
      end
      n_checks++; if (de_out !== 1'b1) begin n_errors++; $display("FAIL relocked_de got=%b exp=1", de_out); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_unlocked();
      test_lock_and_map();
      test_rounding();
      test_geometry();
      test_random();
      test_midline_reset();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/preprocess_pipe.md
Name: preprocess_pipe

Overview:
- Inverse of the 36-bit output packer. Takes a 36-bit, 12-bit-per-channel video stream and returns the 24-bit, 8-bit-per-channel pixel format used inside the binarization datapath.
- Fixed 2-stage pipeline with rounding/saturation. Sync signals are delayed to match the pixel data.
- A frame-lock FSM blanks output until the first complete vsync pulse. Line and frame geometry is measured for debug and for the threshold logic.

Parameters:
- CNT_W, 12, width of the pixel/line counters and of the geometry outputs.
- VS_POL, 1, vsync active level (1 = active-high, 0 = active-low). The FSM always works on the normalized, active-high vsync.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- round_en  in  1  1 = round-half-up with saturation, 0 = truncate
- de_in  in  1  data enable
- hsync_in  in  1  horizontal sync
- vsync_in  in  1  vertical sync, polarity set by VS_POL
- video_in  in  36  {chA[35:24], chB[23:12], chC[11:0]}
- de_out  out  1  data enable, gated by lock
- hsync_out  out  1  hsync delayed 2 cycles
- vsync_out  out  1  vsync delayed 2 cycles, original polarity
- video_out  out  24  8-bit pixel
- frame_locked  out  1  FSM is in LOCKED
- line_px  out  CNT_W  de-high pixels in the last completed line
- frame_lines  out  CNT_W  completed lines in the last completed frame

Behaviour:
- Reset (async, rst_n=0): all pipeline registers, outputs, counters and geometry outputs go to 0. FSM goes to WAIT_VS. The reset takes effect immediately, including mid-frame and mid-pipeline.
- Channel mapping:
  - video_out[7:0] = conv(video_in[35:24])
  - video_out[23:16] = conv(video_in[23:12])
  - video_out[15:8] = conv(video_in[11:0])
- conv(x), with round_en=0: x[11:4].
- conv(x), with round_en=1: compute the 13-bit sum s = x + 8. If s >= 4096 (i.e. x >= 4088) the result is 255, otherwise s[11:4]. No wrap-around is permitted.
- Pipeline:
  - Stage 1 registers video_in, de_in, hsync_in, vs_n = (vsync_in == VS_POL), and round_en.
  - Stage 2 computes conv on the stage-1 data and registers the outputs.
  - Latency is exactly 2 clk from input to output for all of video, de, hsync and vsync. The pipeline has no bubbles and no backpressure.
- Edge detection: uses stage-1 vs_n against its previous value (vs_q), and stage-1 de against de_q.
- FSM states:
  - WAIT_VS: on vs_n rising edge, go to IN_VS.
  - IN_VS: on vs_n falling edge, go to LOCKED.
  - LOCKED: stays locked until reset.
- Gating: de_out <= de_s1 & (state==LOCKED), evaluated with the state before the edge's update. When gated, video_out is forced to 0. hsync_out and vsync_out are never gated.
- frame_locked is registered and equals (state==LOCKED).
- Pixel counter: increments on each stage-1 cycle with de=1, saturating at all-ones. On the de falling edge, line_px latches the counter and the counter clears. If the de rising and falling edges are in the same cycle, the counter counts that as one pixel.
- Line counter: increments on each de falling edge, saturating. On the vs_n rising edge, frame_lines latches it and it clears. If a de falling edge coincides with the vs_n rising edge, the line is counted first, then the count is latched, then the counter clears.
- Counters run in every FSM state. The geometry outputs hold their value between updates.

Decomposition:
- Shared package (pre_post_pkg) holds:
  - the channel bit-slice constants (CH_HI, CH_MID, CH_LO)
  - the FSM state encoding (WAIT_VS=2'd0, IN_VS=2'd1, LOCKED=2'd2)
  - ROUND_BIAS = 8
  - SAT_LIMIT = 4088
- Sub-module px_conv12to8 (one channel, combinational, x and round_en in, 8-bit out). It is instantiated 3 times in stage 2.

Test Plan:
- Reset, then hold vsync low and drive de=1 with video_in=36'hFF0_AB0_120 -> de_out=0, video_out=0, frame_locked=0.
- Pulse vsync high 3 cycles then low, then drive de=1 with video_in=36'hFF0_AB0_120, round_en=0 -> 2 clk later video_out=24'hAB_12_FF, de_out=1, frame_locked=1.
- With round_en=1 drive channels 12'h0F7 / 12'h0F8 / 12'hFFF -> 8'h0F / 8'h10 / 8'hFF (saturation, no wrap).
- 640 de-high cycles per line, 480 lines, then a vsync rising edge -> line_px=640, frame_lines=480, both latched on the correct edges.
- Drive random syncs and video -> hsync_out/vsync_out/de_out/video_out equal the inputs delayed exactly 2 clk (scoreboard).
- Assert rst_n=0 mid-line after lock -> all outputs 0 asynchronously. After release, FSM is in WAIT_VS and de_out=0 until the next complete vsync pulse.
